// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the packed-stream pipeline (packer and unpacker).
//   state_t   : two-state control encoding (IDLE, SHIFT).
//   clamp_cnt : maps a raw lane count onto 1..n_lane; 0 and anything above
//               n_lane mean "full word".
// ---------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int clamp_cnt(input int n, input int n_lane);
        return ((n == 0) || (n > n_lane)) ? n_lane : n;
    endfunction

endpackage

// File: rtl/pipe_unpack.sv
// ---------------------------------------------------------------------------
// pipe_unpack
// Word-to-lane unpacker. Takes one W_DATA-bit word (with a valid-lane count
// and end-of-packet flag) over a valid/ready handshake and emits its valid
// lanes one per cycle, least-significant lane first.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid/o_ready       input word handshake
//   i_data, i_nbytes      input word and its number of valid lanes
//   i_last                input word ends a packet
//   o_valid/i_ready       output lane handshake
//   o_data, o_last        current lane, final lane of an i_last word
//   o_busy                a word is held
// ---------------------------------------------------------------------------
module pipe_unpack
    import pipe_pkg::*;
#(
    parameter  int W_DATA = 32,
    parameter  int W_LANE = 8,
    localparam int N_LANE = W_DATA / W_LANE,
    localparam int W_CNT  = $clog2(N_LANE + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [W_DATA-1:0] i_data,
    input  logic [W_CNT-1:0]  i_nbytes,
    input  logic              i_last,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [W_LANE-1:0] o_data,
    output logic              o_last,
    output logic              o_busy
);

    state_t              r_state;
    logic [W_DATA-1:0]   r_word;
    logic                r_last;
    logic [W_CNT-1:0]    r_cnt;
    logic [W_CNT-1:0]    r_idx;

    state_t              w_state_next;
    logic                w_shift;
    logic                w_final;
    logic                w_in_xfer;
    logic                w_out_xfer;
    logic [W_CNT-1:0]    w_cnt_in;
    logic [W_LANE-1:0]   w_lane;

    assign w_shift    = (r_state == SHIFT);
    assign w_final    = (r_idx == r_cnt - W_CNT'(1));
    assign w_cnt_in   = W_CNT'(clamp_cnt(int'(i_nbytes), N_LANE));
    assign w_lane     = r_word[int'(r_idx) * W_LANE +: W_LANE];

    // Ready depends only on held state and i_ready, so a new word can be
    // taken in the same cycle the final lane leaves (no bubble).
    assign o_ready    = !w_shift || (w_final && i_ready);
    assign w_in_xfer  = i_valid && o_ready;
    assign w_out_xfer = w_shift && i_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        w_state_next = r_state;
        o_valid      = 1'b0;
        o_data       = '0;
        o_last       = 1'b0;
        o_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_in_xfer) w_state_next = SHIFT;
            end
            SHIFT: begin
                o_valid = 1'b1;
                o_data  = w_lane;
                o_last  = r_last && w_final;
                o_busy  = 1'b1;
                if (w_out_xfer && w_final && !w_in_xfer) w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (i_rst) begin
            // NOTE: the held word is a plain register, not a memory array, so
            // clearing it costs nothing and guarantees o_data reads zero.
            r_state <= IDLE;
            r_word  <= '0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_in_xfer) begin
                r_word <= i_data;
                r_last <= i_last;
                r_cnt  <= w_cnt_in;
                r_idx  <= '0;
            end else if (w_out_xfer) begin
                r_idx  <= w_final ? '0 : r_idx + W_CNT'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_unpack.sv
// ---------------------------------------------------------------------------
// tb_pipe_unpack
// Self-checking bench for pipe_unpack: directed per-cycle vector table,
// a long hand-written stall, then randomized traffic against a lane-queue
// reference model.
// ---------------------------------------------------------------------------
module tb_pipe_unpack;

    localparam int W_DATA = 32;
    localparam int W_LANE = 8;
    localparam int N_LANE = W_DATA / W_LANE;
    localparam int W_CNT  = $clog2(N_LANE + 1);

    logic              clk;
    logic              rst;
    logic              valid_in;
    logic              ready_out;
    logic [W_DATA-1:0] data_in;
    logic [W_CNT-1:0]  nbytes_in;
    logic              last_in;
    logic              valid_out;
    logic              ready_in;
    logic [W_LANE-1:0] data_out;
    logic              last_out;
    logic              busy_out;

    int n_checks = 0;
    int n_errors = 0;

    pipe_unpack #(.W_DATA(W_DATA), .W_LANE(W_LANE)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (valid_in),
        .o_ready  (ready_out),
        .i_data   (data_in),
        .i_nbytes (nbytes_in),
        .i_last   (last_in),
        .o_valid  (valid_out),
        .i_ready  (ready_in),
        .o_data   (data_out),
        .o_last   (last_out),
        .o_busy   (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic              valid;
        logic [W_DATA-1:0] data;
        logic [W_CNT-1:0]  nb;
        logic              last;
        logic              ready;
        logic              chk;
        logic              ev;
        logic              er;
        logic [W_LANE-1:0] ed;
        logic              el;
        logic              eb;
    } vec_t;

    typedef struct {
        logic [W_LANE-1:0] d;
        logic              l;
    } lane_t;

    vec_t  vecs[$];
    lane_t model_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic v(input logic r, input logic vi, input logic [W_DATA-1:0] d,
                     input logic [W_CNT-1:0] nb, input logic l, input logic rdy,
                     input logic chk, input logic ev, input logic er,
                     input logic [W_LANE-1:0] ed, input logic el, input logic eb);
        vec_t t;
        t.rst = r; t.valid = vi; t.data = d; t.nb = nb; t.last = l; t.ready = rdy;
        t.chk = chk; t.ev = ev; t.er = er; t.ed = ed; t.el = el; t.eb = eb;
        vecs.push_back(t);
    endtask

    // Row where no word is held: outputs idle, o_ready high.
    task automatic idle(input logic vi, input logic [W_DATA-1:0] d,
                        input logic [W_CNT-1:0] nb, input logic l, input logic rdy);
        v(1'b0, vi, d, nb, l, rdy, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    endtask

    // Row where a lane is being shown.
    task automatic lane(input logic vi, input logic [W_DATA-1:0] d,
                        input logic [W_CNT-1:0] nb, input logic l, input logic rdy,
                        input logic [W_LANE-1:0] ed, input logic el, input logic er);
        v(1'b0, vi, d, nb, l, rdy, 1'b1, 1'b1, er, ed, el, 1'b1);
    endtask

    task automatic drive(input logic r, input logic vi, input logic [W_DATA-1:0] d,
                         input logic [W_CNT-1:0] nb, input logic l, input logic rdy);
        rst = r; valid_in = vi; data_in = d; nbytes_in = nb; last_in = l; ready_in = rdy;
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic er,
                                 input logic [W_LANE-1:0] ed, input logic el, input logic eb);
        check({tag, ".o_valid"}, 32'(valid_out), 32'(ev));
        check({tag, ".o_ready"}, 32'(ready_out), 32'(er));
        check({tag, ".o_data"},  32'(data_out),  32'(ed));
        check({tag, ".o_last"},  32'(last_out),  32'(el));
        check({tag, ".o_busy"},  32'(busy_out),  32'(eb));
    endtask

    // Reference model: the held word is a queue of pending lanes.
    task automatic model_push(input logic [W_DATA-1:0] d, input int nb, input logic l);
        int cnt;
        lane_t e;
        cnt = (nb == 0 || nb > N_LANE) ? N_LANE : nb;
        for (int k = 0; k < cnt; k++) begin
            e.d = d[k*W_LANE +: W_LANE];
            e.l = l && (k == cnt - 1);
            model_q.push_back(e);
        end
    endtask

    localparam logic [31:0] W1 = 32'hDDCC_BBAA;
    localparam logic [31:0] W2 = 32'h4433_2211;

    initial begin
        logic exp_ready;
        drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);

        // ---- directed vector table (inputs applied, outputs checked, then edge)
        v(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        v(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        // full 4-lane word with i_last
        idle(1'b1, W1, 3'd4, 1'b1, 1'b1);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b0);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b0);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'hDD, 1'b1, 1'b1);
        idle(1'b0, '0, '0, 1'b0, 1'b1);
        // 2-lane word: CC/DD never emitted
        idle(1'b1, W1, 3'd2, 1'b1, 1'b1);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'hBB, 1'b1, 1'b1);
        idle(1'b0, '0, '0, 1'b0, 1'b1);
        // back-to-back single-lane words, i_valid held high
        idle(1'b1, 32'h0000_0011, 3'd1, 1'b0, 1'b1);
        lane(1'b1, 32'h0000_0022, 3'd1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1);
        lane(1'b1, 32'h0000_0033, 3'd1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1);
        idle(1'b0, '0, '0, 1'b0, 1'b1);
        // 3-cycle stall on BB, with junk offered on the input meanwhile
        idle(1'b1, W1, 3'd4, 1'b0, 1'b1);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        lane(1'b1, 32'hEEEE_EEEE, 3'd1, 1'b1, 1'b0, 8'hBB, 1'b0, 1'b0);
        lane(1'b1, 32'hEEEE_EEEE, 3'd1, 1'b1, 1'b0, 8'hBB, 1'b0, 1'b0);
        lane(1'b1, 32'hEEEE_EEEE, 3'd1, 1'b1, 1'b0, 8'hBB, 1'b0, 1'b0);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b0);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b0);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'hDD, 1'b0, 1'b1);
        idle(1'b0, '0, '0, 1'b0, 1'b1);
        // nbytes=0 clamps to 4
        idle(1'b1, W1, 3'd0, 1'b1, 1'b1);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b0);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b0);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'hDD, 1'b1, 1'b1);
        idle(1'b0, '0, '0, 1'b0, 1'b1);
        // nbytes=7 clamps to 4; stall on the final lane holds o_ready low
        idle(1'b1, W1, 3'd7, 1'b0, 1'b1);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b0);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b0);
        lane(1'b1, W2, 3'd4, 1'b0, 1'b0, 8'hDD, 1'b0, 1'b0);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'hDD, 1'b0, 1'b1);
        idle(1'b0, '0, '0, 1'b0, 1'b1);
        // reset after lane BB discards the rest of the word
        idle(1'b1, W1, 3'd4, 1'b1, 1'b1);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b0);
        v(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hCC, 1'b0, 1'b1);
        idle(1'b1, W2, 3'd3, 1'b1, 1'b1);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        lane(1'b0, '0, '0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1);
        idle(1'b0, '0, '0, 1'b0, 1'b1);

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].nb, vecs[i].last, vecs[i].ready);
            #2;
            if (vecs[i].chk)
                check_outputs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er,
                              vecs[i].ed, vecs[i].el, vecs[i].eb);
            @(posedge clk); #1;
        end

        // ---- long stall on lane 0, then drain
        drive(1'b0, 1'b1, W2, 3'd2, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            #2;
            check_outputs($sformatf("stall%0d", c), 1'b1, 1'b0, 8'h11, 1'b0, 1'b1);
            @(posedge clk); #1;
        end
        ready_in = 1'b1;
        #2;
        check_outputs("stall_rel0", 1'b1, 1'b0, 8'h11, 1'b0, 1'b1);
        @(posedge clk); #1;
        #2;
        check_outputs("stall_rel1", 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
        @(posedge clk); #1;

        // ---- randomized traffic against the lane-queue model
        drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        @(posedge clk); #1;
        model_q.delete();
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(63) == 0), 1'($urandom_range(1)), $urandom,
                  W_CNT'($urandom_range(7)), 1'($urandom_range(1)),
                  ($urandom_range(3) != 0));
            #2;
            exp_ready = (model_q.size() == 0) || (model_q.size() == 1 && ready_in);
            if (model_q.size() > 0)
                check_outputs($sformatf("rnd%0d", c), 1'b1, exp_ready,
                              model_q[0].d, model_q[0].l, 1'b1);
            else
                check_outputs($sformatf("rnd%0d", c), 1'b0, exp_ready,
                              8'h00, 1'b0, 1'b0);
            if (rst) begin
                model_q.delete();
            end else begin
                if (model_q.size() > 0 && ready_in) void'(model_q.pop_front());
                if (valid_in && exp_ready) model_push(data_in, int'(nbytes_in), last_in);
            end
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_unpack.md
# pipe_unpack

Word-to-lane unpacker on the consumer side of the pipeline's packed stream. Accepts one W_DATA-bit word with a valid-lane count and an end-of-packet flag over a valid/ready handshake. Emits the valid lanes one at a time, least-significant lane first, over a second valid/ready handshake. Sits between the wide internal datapath and narrow byte-oriented sinks.

## Interface
- W_DATA, 32, input word width; must be a multiple of W_LANE.
- W_LANE, 8, output lane width.
- N_LANE, W_DATA/W_LANE, derived localparam: lanes per word.
- W_CNT, $clog2(N_LANE+1), derived localparam: width of lane counts.
- i_clk  input  1  single clock; all logic on posedge.
- i_rst  input  1  reset, synchronous, active-high.
- i_valid  input  1  input word valid.
- o_ready  output  1  unpacker can take a word this cycle.
- i_data  input  W_DATA  input word; lane k = i_data[k*W_LANE +: W_LANE].
- i_nbytes  input  W_CNT  number of valid lanes, starting from lane 0.
- i_last  input  1  word ends a packet.
- o_valid  output  1  output lane valid.
- i_ready  input  1  downstream accepts lane.
- o_data  output  W_LANE  current lane.
- o_last  output  1  final lane of a word that carried i_last.
- o_busy  output  1  a word is held (state SHIFT).

## Operation
- States:
  - IDLE: no word held.
  - SHIFT: word held in register, lane index `idx` in 0..cnt-1.
- Input transfer occurs when i_valid && o_ready. Output transfer occurs when o_valid && i_ready.
- On input transfer, capture i_data, i_last, and cnt. Set idx=0 and go to SHIFT.
- cnt clamping: i_nbytes == 0 or > N_LANE is clamped to N_LANE. Values 1..N_LANE are taken as given.
- In SHIFT, the outputs are driven as follows:
  - o_valid=1.
  - o_data = held lane idx.
  - o_last = held_last && (idx == cnt-1).
- Advancing on output transfer:
  - If idx < cnt-1, increment idx.
  - If idx == cnt-1 and i_valid is high, capture the new word (back-to-back, no bubble) and stay in SHIFT with idx=0.
  - If idx == cnt-1 and i_valid is low, return to IDLE.
- o_ready = (state == IDLE) || (idx == cnt-1 && i_ready). This is combinational from i_ready. It has no path from i_valid.
- o_valid stays high and o_data/o_last stay stable while i_ready is low. Stall can last indefinitely.
- i_data, i_nbytes, and i_last are ignored when no input transfer occurs.
- o_busy mirrors state == SHIFT.

## Timing
- Reset: i_rst high at a posedge forces the following, regardless of traffic or state:
  - state=IDLE, idx=0.
  - o_valid=0, o_last=0, o_busy=0.
  - o_data=0, held register cleared.
  - o_ready is 1 from the first cycle after reset deasserts.
- Reset mid-word discards the remaining lanes. No partial lane is emitted after reset.
- Latency: a word accepted at edge t presents lane 0 from cycle t+1.
- Throughput:
  - Sustained 1 lane/cycle when i_ready is held high.
  - A word with cnt lanes occupies exactly cnt cycles.
  - cnt=1 words stream at 1 word/cycle.
- Simultaneous final-lane output and new-word input in the same cycle: both transfers complete. The new lane 0 is visible next cycle.
- No combinational path from i_valid/i_data to any output. o_ready depends only on registered state and i_ready.

## Structure
- Shared package pipe_pkg holds:
  - the state enum (IDLE, SHIFT);
  - the lane-count clamp function clamp_cnt(n, N_LANE).
- The pipeline's packer reuses both.
- Single module; no sub-module. The datapath is a held-word register with a lane mux indexed by idx.

## Test plan
- Reset then i_valid with i_data=32'hDDCC_BBAA, i_nbytes=4, i_last=1, i_ready=1 -> o_data AA, BB, CC, DD on cycles t+1..t+4. o_last=1 only with DD. o_valid=0 at t+5.
- Same word with i_nbytes=2 -> AA then BB(o_last=1). CC and DD are never emitted.
- Two words back-to-back, i_nbytes=1 each, i_valid held high -> o_ready=1 every cycle, one lane per cycle, no idle cycle between words.
- i_ready low for 3 cycles while lane BB is shown -> o_data stays BB with o_valid=1 and o_ready=0. On release, the sequence resumes at CC.
- i_nbytes=0 and i_nbytes=7 -> each clamped to 4 lanes, all emitted.
- i_rst asserted after lane BB of a 4-lane word -> next cycle o_valid=0, o_busy=0, o_ready=1. A following word starts cleanly at its lane 0.
